// File: rtl/cpu_pkg.sv
// cpu_pkg: constants shared across the CPU datapath.
//   DATA_W          - datapath width in bits
//   REG_A .. REG_D  - register addresses; the bus multiplexer select
//                     uses the same encoding
package cpu_pkg;

    localparam int DATA_W = 8;

    localparam logic [1:0] REG_A = 2'd0;
    localparam logic [1:0] REG_B = 2'd1;
    localparam logic [1:0] REG_C = 2'd2;
    localparam logic [1:0] REG_D = 2'd3;

endpackage : cpu_pkg

// File: rtl/reg_cell.sv
// reg_cell: one WIDTH-bit register with load, increment and decrement.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset to RST_VAL
//   ld    - load d (has priority over counting)
//   d     - load data
//   inc   - increment by one, modulo 2^WIDTH
//   dec   - decrement by one, modulo 2^WIDTH
//   q     - register contents
//   wrap  - combinational: the count applied at the coming edge wraps
//           (all-ones -> zero on inc, zero -> all-ones on dec)
module reg_cell #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] q,
    output logic             wrap
);

    logic do_inc;
    logic do_dec;

    // inc and dec together cancel out; a load suppresses both.
    assign do_inc = !ld && inc && !dec;
    assign do_dec = !ld && dec && !inc;

    assign wrap = (do_inc && (q == '1)) || (do_dec && (q == '0));

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (ld) begin
            q <= d;
        end else if (do_inc) begin
            q <= q + 1'b1;
        end else if (do_dec) begin
            q <= q - 1'b1;
        end
    end

endmodule : reg_cell

// File: rtl/reg_bank.sv
// reg_bank: four 8-bit registers feeding the CPU's 4:1 data-bus multiplexer.
// Each register can be loaded from the bus or counted up/down in place.
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset (A..C -> 0, D -> RST_D)
//   wr_en     - write wr_data into register wr_addr
//   wr_addr   - write target (REG_A..REG_D)
//   wr_data   - write data from the bus multiplexer
//   inc_en    - increment register cnt_addr
//   dec_en    - decrement register cnt_addr
//   cnt_addr  - count target (REG_A..REG_D)
//   A, B, C, D - registered contents
//   zero      - zero[i] high when register i is all zeros (from state only)
//   wrap      - registered one-cycle pulse after a counted register wrapped
module reg_bank
    import cpu_pkg::*;
#(
    parameter int               WIDTH = DATA_W,
    parameter logic [WIDTH-1:0] RST_D = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [1:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             inc_en,
    input  logic             dec_en,
    input  logic [1:0]       cnt_addr,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] D,
    output logic [3:0]       zero,
    output logic             wrap
);

    logic [WIDTH-1:0] q [4];
    logic [3:0]       ld;
    logic [3:0]       inc;
    logic [3:0]       dec;
    logic [3:0]       cell_wrap;

    // Per-cell enable decode. A write to the same register as the count
    // drops the count, so that cell never reports a wrap.
    // NOTE: every always_comb output gets a default before any conditional
    // assignment, so no latch can be inferred.
    always_comb begin
        ld  = '0;
        inc = '0;
        dec = '0;
        for (int i = 0; i < 4; i++) begin
            ld[i] = wr_en && (wr_addr == 2'(i));
            if ((inc_en ^ dec_en) && (cnt_addr == 2'(i)) && !ld[i]) begin
                inc[i] = inc_en;
                dec[i] = dec_en;
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_cell
        localparam logic [WIDTH-1:0] RST_VAL = (g == int'(REG_D)) ? RST_D : '0;

        reg_cell #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_cell (
            .clk  (clk),
            .rst  (rst),
            .ld   (ld[g]),
            .d    (wr_data),
            .inc  (inc[g]),
            .dec  (dec[g]),
            .q    (q[g]),
            .wrap (cell_wrap[g])
        );
    end

    assign A = q[REG_A];
    assign B = q[REG_B];
    assign C = q[REG_C];
    assign D = q[REG_D];

    always_comb begin
        zero = '0;
        for (int i = 0; i < 4; i++) begin
            zero[i] = (q[i] == '0);
        end
    end

    // Registered so the pulse lines up with the wrapped value on the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrap <= 1'b0;
        end else begin
            wrap <= |cell_wrap;
        end
    end

endmodule : reg_bank

// File: tb/tb_reg_bank.sv
// tb_reg_bank: directed self-checking bench for reg_bank (RST_D = 8'h10).
module tb_reg_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       inc_en;
    logic       dec_en;
    logic [1:0] cnt_addr;
    logic [7:0] A, B, C, D;
    logic [3:0] zero;
    logic       wrap;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_bank #(
        .WIDTH (8),
        .RST_D (8'h10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .inc_en   (inc_en),
        .dec_en   (dec_en),
        .cnt_addr (cnt_addr),
        .A        (A),
        .B        (B),
        .C        (C),
        .D        (D),
        .zero     (zero),
        .wrap     (wrap)
    );

    task automatic check(input string tag, input logic [7:0] observed,
                         input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Present one cycle of inputs, clock it, and settle 1 time unit past the edge.
    task automatic cyc(input logic r, input logic we, input logic [1:0] wa,
                       input logic [7:0] wd, input logic ie, input logic de,
                       input logic [1:0] ca);
        rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
        inc_en = ie; dec_en = de; cnt_addr = ca;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        cyc(1, 0, 0, 8'h00, 0, 0, 0);
        cyc(1, 0, 0, 8'h00, 0, 0, 0);
        check("rst_A", A, 8'h00);
        check("rst_B", B, 8'h00);
        check("rst_C", C, 8'h00);
        check("rst_D", D, 8'h10);
        check("rst_zero", {4'h0, zero}, 8'h07);
        check("rst_wrap", {7'd0, wrap}, 8'h00);

        // Consecutive writes
        cyc(0, 1, 2'd1, 8'hA5, 0, 0, 0);
        check("wrB_B", B, 8'hA5);
        check("wrB_C", C, 8'h00);
        cyc(0, 1, 2'd2, 8'h3C, 0, 0, 0);
        check("wrC_C", C, 8'h3C);
        check("wrC_B", B, 8'hA5);
        check("wrC_A", A, 8'h00);
        check("wrC_D", D, 8'h10);
        check("wrC_zero", {4'h0, zero}, 8'h01);

        // D increment through wrap
        cyc(0, 1, 2'd3, 8'hFE, 0, 0, 0);
        check("ldD", D, 8'hFE);
        cyc(0, 0, 0, 8'h00, 1, 0, 2'd3);
        check("inc1_D", D, 8'hFF);
        check("inc1_wrap", {7'd0, wrap}, 8'h00);
        check("inc1_z3", {7'd0, zero[3]}, 8'h00);
        cyc(0, 0, 0, 8'h00, 1, 0, 2'd3);
        check("inc2_D", D, 8'h00);
        check("inc2_wrap", {7'd0, wrap}, 8'h01);
        check("inc2_z3", {7'd0, zero[3]}, 8'h01);
        cyc(0, 0, 0, 8'h00, 1, 0, 2'd3);
        check("inc3_D", D, 8'h01);
        check("inc3_wrap", {7'd0, wrap}, 8'h00);
        check("inc3_z3", {7'd0, zero[3]}, 8'h00);

        // A decrement through wrap, then inc+dec together
        cyc(0, 0, 0, 8'h00, 0, 1, 2'd0);
        check("dec_A", A, 8'hFF);
        check("dec_wrap", {7'd0, wrap}, 8'h01);
        check("dec_z0", {7'd0, zero[0]}, 8'h00);
        cyc(0, 0, 0, 8'h00, 1, 1, 2'd0);
        check("both_A", A, 8'hFF);
        check("both_wrap", {7'd0, wrap}, 8'h00);

        // Write/count same-register and cross-register
        cyc(0, 1, 2'd2, 8'h12, 0, 0, 0);
        cyc(0, 1, 2'd3, 8'h20, 0, 0, 0);
        check("setC", C, 8'h12);
        check("setD", D, 8'h20);
        cyc(0, 1, 2'd2, 8'h77, 1, 0, 2'd2);
        check("wr_over_inc_C", C, 8'h77);
        cyc(0, 1, 2'd0, 8'h01, 1, 0, 2'd3);
        check("cross_A", A, 8'h01);
        check("cross_D", D, 8'h21);
        check("cross_C", C, 8'h77);

        // A write over a count that would have wrapped suppresses wrap
        cyc(0, 1, 2'd2, 8'hFF, 0, 0, 0);
        cyc(0, 1, 2'd2, 8'h00, 1, 0, 2'd2);
        check("wr_over_wrap_C", C, 8'h00);
        check("wr_over_wrap_wrap", {7'd0, wrap}, 8'h00);

        // Reset discards a same-cycle write
        cyc(1, 1, 2'd1, 8'h55, 0, 0, 0);
        check("rstwr_B", B, 8'h00);
        check("rstwr_D", D, 8'h10);
        check("rstwr_A", A, 8'h00);
        cyc(0, 1, 2'd1, 8'h55, 0, 0, 0);
        check("postrst_B", B, 8'h55);
        check("postrst_zero", {4'h0, zero}, 8'h05);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_reg_bank
